alu_op_issuer: RTL and testbench
================================

Name: alu_op_issuer

Overview:
- Initiator side of the ALU add/subtract unit interface.
- Accepts operand commands on a valid/ready port and drives a, b and add_nsub into a fixed-latency arithmetic unit.
- Counts the unit's pipeline latency, captures the unit's result and returns it with the command's tag on a valid/ready response port.
- Sits between the ALU command decoder and the add/sub unit; one operation in flight at a time.

Parameters:
IN_WL, 15, operand word length (matches arithmetic unit input width)
OUT_WL, 16, result word length (matches arithmetic unit output width); must be >= IN_WL+1
UNIT_LAT, 2, cycles from operands presented to unit result valid; must be >= 1
TAG_WL, 4, command tag width

Ports:
clk  input  1  clock, rising edge
rstb  input  1  reset, asynchronous, active-low
cmd_valid  input  1  command present
cmd_ready  output  1  issuer can accept command
cmd_a  input  IN_WL  operand a
cmd_b  input  IN_WL  operand b
cmd_add_nsub  input  1  1: a+b, 0: a-b
cmd_tag  input  TAG_WL  command identifier, returned with result
unit_a  output  IN_WL  operand a to arithmetic unit
unit_b  output  IN_WL  operand b to arithmetic unit
unit_add_nsub  output  1  operation select to arithmetic unit
unit_r  input  OUT_WL  result from arithmetic unit
rsp_valid  output  1  result present
rsp_ready  input  1  consumer accepts result
rsp_r  output  OUT_WL  captured result
rsp_tag  output  TAG_WL  tag of captured result
busy  output  1  operation in flight (state != IDLE)

Behaviour:
- Interface: one clock (clk); reset is asynchronous, active-low (rstb).
- Reset values: state=IDLE, cmd_ready=1, rsp_valid=0, busy=0, unit_a/unit_b/rsp_r/rsp_tag=0, unit_add_nsub=0, lat_cnt=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready at edge E0: register cmd_a/cmd_b/cmd_add_nsub into unit_*, store cmd_tag, load lat_cnt=UNIT_LAT, go WAIT.
- WAIT:
  - cmd_ready=0; unit_* held constant.
  - lat_cnt decrements each edge.
  - At the edge where lat_cnt==1 (edge E0+UNIT_LAT): capture unit_r into rsp_r, stored tag into rsp_tag, go RESP.
  - The captured value is the unit's response to the operands registered at E0.
- RESP:
  - rsp_valid=1; rsp_r and rsp_tag stable until handshake.
  - cmd_ready=0.
  - On rsp_valid&&rsp_ready: rsp_valid falls at that edge, go IDLE.
  - Next command is accepted at the earliest one cycle later.
- Throughput: one result per UNIT_LAT+2 cycles with no backpressure.
- Arithmetic contract (unit side, used by the checker): operands are unsigned and zero-extended to OUT_WL.
  - add: (a+b) mod 2^OUT_WL.
  - sub: (a-b) mod 2^OUT_WL, i.e. two's-complement wrap for a<b.
- Backpressure: rsp_ready low holds RESP indefinitely; unit_* stay at last operands; no further commands accepted.
- cmd_valid may toggle freely while cmd_ready=0; it is ignored.
- Reset mid-operation (WAIT or RESP): asynchronous return to reset values; the in-flight result is discarded and no response is produced.
- UNIT_LAT=1: WAIT lasts exactly one cycle.

Optional Feature:
- Macro: ALU_OP_ISSUER_CHECK_EN.
- With macro:
  - Extra output port chk_err (1 bit, reset 0).
  - At capture, the block computes the expected result per the arithmetic contract and compares it with unit_r.
  - chk_err is a sticky 1 on any mismatch; it is cleared only by rstb.
- Without macro: no chk_err port, no comparison logic.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [1:0] issuer_state_t {IDLE, WAIT, RESP}.
  - localparam defaults for IN_WL/OUT_WL.
  - function exp_result(a, b, add_nsub) implementing the arithmetic contract, shared with the bench scoreboard.
- Sub-module: none required. The latency counter may be a small generic down-counter module, lat_counter, with load/dec/zero outputs; this is optional.

Test Plan:
- Add: a=5, b=3, add_nsub=1, tag=0x2, unit model returns 8 after 2 cycles -> rsp_r=0x0008, rsp_tag=0x2, rsp_valid rises exactly UNIT_LAT cycles after cmd handshake edge.
- Sub wrap: a=3, b=5, add_nsub=0 -> rsp_r=0xFFFE.
- Full range: a=0x7FFF, b=0x7FFF, add_nsub=1 -> rsp_r=0xFFFE; unit_a/unit_b held at 0x7FFF throughout WAIT.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_r/rsp_tag stable, cmd_ready=0, cmd_valid pulses ignored; rsp_ready=1 -> IDLE next cycle, next command accepted.
- Reset in WAIT: assert rstb low 1 cycle after handshake -> all outputs immediately at reset values, no rsp_valid produced; a new command after reset completes normally.
- Checker (macro on): unit model returns 7 for 5+3 -> chk_err=1, still set after a subsequent correct operation; macro off builds without the chk_err port.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types, default widths and arithmetic contract for the ALU op issuer
package alu_pkg;

  localparam int ALU_IN_WL    = 15;
  localparam int ALU_OUT_WL   = 16;
  localparam int ALU_UNIT_LAT = 2;
  localparam int ALU_TAG_WL   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } issuer_state_t;

  // Operands are unsigned, zero-extended to the result width; subtraction wraps.
  function automatic logic [ALU_OUT_WL-1:0] exp_result(
    input logic [ALU_IN_WL-1:0] a,
    input logic [ALU_IN_WL-1:0] b,
    input logic                 add_nsub
  );
    logic [ALU_OUT_WL-1:0] a_ext;
    logic [ALU_OUT_WL-1:0] b_ext;
    a_ext = ALU_OUT_WL'(a);
    b_ext = ALU_OUT_WL'(b);
    return add_nsub ? (a_ext + b_ext) : (a_ext - b_ext);
  endfunction

endpackage

// File: rtl/alu_op_issuer.sv
// rtl/alu_op_issuer.sv - issues one add/sub to a fixed-latency unit and returns the tagged result
// Optional result checker (chk_err output) enabled by defining ALU_OP_ISSUER_CHECK_EN.
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int IN_WL    = ALU_IN_WL,
  parameter int OUT_WL   = ALU_OUT_WL,
  parameter int UNIT_LAT = ALU_UNIT_LAT,
  parameter int TAG_WL   = ALU_TAG_WL
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [IN_WL-1:0]  cmd_a,
  input  logic [IN_WL-1:0]  cmd_b,
  input  logic              cmd_add_nsub,
  input  logic [TAG_WL-1:0] cmd_tag,
  output logic [IN_WL-1:0]  unit_a,
  output logic [IN_WL-1:0]  unit_b,
  output logic              unit_add_nsub,
  input  logic [OUT_WL-1:0] unit_r,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [OUT_WL-1:0] rsp_r,
  output logic [TAG_WL-1:0] rsp_tag,
  output logic              busy
`ifdef ALU_OP_ISSUER_CHECK_EN
  ,
  output logic              chk_err
`endif
);

  localparam int LAT_W = $clog2(UNIT_LAT + 1);

  issuer_state_t     r_state;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic              r_busy;
  logic [IN_WL-1:0]  r_unit_a;
  logic [IN_WL-1:0]  r_unit_b;
  logic              r_unit_add_nsub;
  logic [OUT_WL-1:0] r_rsp_r;
  logic [TAG_WL-1:0] r_rsp_tag;
  logic [TAG_WL-1:0] r_tag;
  logic [LAT_W-1:0]  r_lat_cnt;

`ifdef ALU_OP_ISSUER_CHECK_EN
  logic              r_chk_err;
  logic [OUT_WL-1:0] w_a_ext;
  logic [OUT_WL-1:0] w_b_ext;
  logic [OUT_WL-1:0] w_exp;

  assign w_a_ext = OUT_WL'(r_unit_a);
  assign w_b_ext = OUT_WL'(r_unit_b);
  assign w_exp   = r_unit_add_nsub ? (w_a_ext + w_b_ext) : (w_a_ext - w_b_ext);
  assign chk_err = r_chk_err;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state         <= IDLE;
      r_cmd_ready     <= 1'b1;
      r_rsp_valid     <= 1'b0;
      r_busy          <= 1'b0;
      r_unit_a        <= '0;
      r_unit_b        <= '0;
      r_unit_add_nsub <= 1'b0;
      r_rsp_r         <= '0;
      r_rsp_tag       <= '0;
      r_tag           <= '0;
      r_lat_cnt       <= '0;
`ifdef ALU_OP_ISSUER_CHECK_EN
      r_chk_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_unit_a        <= cmd_a;
            r_unit_b        <= cmd_b;
            r_unit_add_nsub <= cmd_add_nsub;
            r_tag           <= cmd_tag;
            r_lat_cnt       <= LAT_W'(UNIT_LAT);
            r_cmd_ready     <= 1'b0;
            r_busy          <= 1'b1;
            r_state         <= WAIT;
          end
        end
        WAIT: begin
          r_lat_cnt <= r_lat_cnt - LAT_W'(1);
          // Unit operands have been stable for UNIT_LAT edges, so unit_r is valid now.
          if (r_lat_cnt == LAT_W'(1)) begin
            r_rsp_r     <= unit_r;
            r_rsp_tag   <= r_tag;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
`ifdef ALU_OP_ISSUER_CHECK_EN
            if (unit_r != w_exp) r_chk_err <= 1'b1;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign unit_a        = r_unit_a;
  assign unit_b        = r_unit_b;
  assign unit_add_nsub = r_unit_add_nsub;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_r         = r_rsp_r;
  assign rsp_tag       = r_rsp_tag;
  assign busy          = r_busy;

endmodule

// File: tb/tb_alu_op_issuer.sv
// tb/tb_alu_op_issuer.sv - directed self-checking bench for alu_op_issuer with a one-register unit model
module tb_alu_op_issuer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [14:0] cmd_a = '0;
  logic [14:0] cmd_b = '0;
  logic        cmd_add_nsub = 1'b0;
  logic [3:0]  cmd_tag = '0;
  logic [14:0] unit_a;
  logic [14:0] unit_b;
  logic        unit_add_nsub;
  logic [15:0] unit_r;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_r;
  logic [3:0]  rsp_tag;
  logic        busy;
`ifdef ALU_OP_ISSUER_CHECK_EN
  logic        chk_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Unit model: result register fed from the presented operands; fault skews it by -1.
  logic        fault = 1'b0;
  logic [15:0] r_model;
  always_ff @(posedge clk) r_model <= exp_result(unit_a, unit_b, unit_add_nsub) - (fault ? 16'd1 : 16'd0);
  assign unit_r = r_model;

  always #5 clk = ~clk;

  alu_op_issuer dut (
    .clk           (clk),
    .rstb          (rstb),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .cmd_add_nsub  (cmd_add_nsub),
    .cmd_tag       (cmd_tag),
    .unit_a        (unit_a),
    .unit_b        (unit_b),
    .unit_add_nsub (unit_add_nsub),
    .unit_r        (unit_r),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_r         (rsp_r),
    .rsp_tag       (rsp_tag),
    .busy          (busy)
`ifdef ALU_OP_ISSUER_CHECK_EN
    ,
    .chk_err       (chk_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the handshake edge E0.
  task automatic send(input logic [14:0] a, input logic [14:0] b, input logic op, input logic [3:0] tag);
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_add_nsub = op;
    cmd_tag = tag;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_cmd_ready", 32'(cmd_ready), 32'd0);
    check("accept_unit_a", 32'(unit_a), 32'(a));
    check("accept_unit_b", 32'(unit_b), 32'(b));
    check("accept_unit_op", 32'(unit_add_nsub), 32'(op));
  endtask

  // rsp_valid must stay low for UNIT_LAT-1 cycles and rise on edge E0+UNIT_LAT.
  task automatic expect_rsp(input logic [14:0] a, input logic [14:0] b, input logic [15:0] r, input logic [3:0] tag);
    for (int i = 1; i < ALU_UNIT_LAT; i++) begin
      check("wait_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("wait_unit_a_held", 32'(unit_a), 32'(a));
      check("wait_unit_b_held", 32'(unit_b), 32'(b));
    end
    check("wait_rsp_valid_last", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_r", 32'(rsp_r), 32'(r));
    check("rsp_tag", 32'(rsp_tag), 32'(tag));
    check("rsp_cmd_ready", 32'(cmd_ready), 32'd0);
  endtask

  task automatic retire();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("retire_rsp_valid", 32'(rsp_valid), 32'd0);
    check("retire_cmd_ready", 32'(cmd_ready), 32'd1);
    check("retire_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_unit_a", 32'(unit_a), 32'd0);
    check("reset_rsp_r", 32'(rsp_r), 32'd0);
    check("reset_rsp_tag", 32'(rsp_tag), 32'd0);
`ifdef ALU_OP_ISSUER_CHECK_EN
    check("reset_chk_err", 32'(chk_err), 32'd0);
`endif
    rstb = 1'b1;
    @(negedge clk);

    send(15'd5, 15'd3, 1'b1, 4'h2);
    expect_rsp(15'd5, 15'd3, 16'h0008, 4'h2);
    retire();

    send(15'd3, 15'd5, 1'b0, 4'h5);
    expect_rsp(15'd3, 15'd5, 16'hFFFE, 4'h5);
    retire();

    send(15'h7FFF, 15'h7FFF, 1'b1, 4'hF);
    expect_rsp(15'h7FFF, 15'h7FFF, 16'hFFFE, 4'hF);
    retire();

    // Backpressure: hold rsp_ready low while spamming commands that must be ignored.
    send(15'h0100, 15'h0023, 1'b1, 4'h9);
    expect_rsp(15'h0100, 15'h0023, 16'h0123, 4'h9);
    for (int i = 0; i < 10; i++) begin
      cmd_valid = i[0];
      cmd_a = 15'(i + 100);
      cmd_b = 15'(i + 7);
      cmd_tag = 4'(i);
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_r", 32'(rsp_r), 32'h0123);
      check("bp_rsp_tag", 32'(rsp_tag), 32'h9);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_unit_a", 32'(unit_a), 32'h0100);
    end
    cmd_valid = 1'b0;
    retire();
    send(15'h0010, 15'h0004, 1'b0, 4'h1);
    expect_rsp(15'h0010, 15'h0004, 16'h000C, 4'h1);
    retire();

    // Reset while in WAIT: everything returns to reset values immediately.
    send(15'h0200, 15'h0001, 1'b1, 4'hA);
    @(posedge clk);
    #2 rstb = 1'b0;
    #1;
    check("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_wait_busy", 32'(busy), 32'd0);
    check("rst_wait_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_wait_unit_a", 32'(unit_a), 32'd0);
    check("rst_wait_unit_b", 32'(unit_b), 32'd0);
    check("rst_wait_rsp_r", 32'(rsp_r), 32'd0);
    check("rst_wait_rsp_tag", 32'(rsp_tag), 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end
    send(15'h1234, 15'h0111, 1'b1, 4'h6);
    expect_rsp(15'h1234, 15'h0111, 16'h1345, 4'h6);
    retire();

`ifdef ALU_OP_ISSUER_CHECK_EN
    check("chk_clean", 32'(chk_err), 32'd0);
    fault = 1'b1;
    send(15'd5, 15'd3, 1'b1, 4'h3);
    expect_rsp(15'd5, 15'd3, 16'h0007, 4'h3);
    check("chk_err_set", 32'(chk_err), 32'd1);
    retire();
    fault = 1'b0;
    send(15'd20, 15'd2, 1'b0, 4'h4);
    expect_rsp(15'd20, 15'd2, 16'h0012, 4'h4);
    retire();
    check("chk_err_sticky", 32'(chk_err), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
